// File: rtl/hs_fifo_stage_if.sv
// Handshake bus for hs_fifo_stage: upstream req_l/ack_l/din, downstream req_r/ack_r/dout, plus status.
// master = the buffer stage, slave = the producer/consumer environment.
interface hs_fifo_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
);
   localparam int CNT_WIDTH = $clog2(DEPTH + 1);

   logic                  req_l;
   logic                  ack_l;
   logic [DATA_WIDTH-1:0] din;
   logic                  req_r;
   logic                  ack_r;
   logic [DATA_WIDTH-1:0] dout;
   logic [CNT_WIDTH-1:0]  count;
   logic                  full;
   logic                  empty;
   logic [CNT_WIDTH-1:0]  max_occ;
   logic [31:0]           stall_cnt;

   modport master (
      output req_l, ack_r, dout, count, full, empty, max_occ, stall_cnt,
      input  ack_l, din, req_r
   );

   modport slave (
      input  req_l, ack_r, dout, count, full, empty, max_occ, stall_cnt,
      output ack_l, din, req_r
   );
endinterface

// File: rtl/hs_fifo_stage.sv
// Elastic req/ack buffer between a stream producer and a dataflow node (or node and consumer).
// Optional HS_FIFO_STATS_EN adds a high-water mark and a downstream starvation counter.
module hs_fifo_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic            clk,
   input  logic            rst,
   hs_fifo_stage_if.master bus
);
   localparam int CNT_WIDTH = $clog2(DEPTH + 1);
   localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_WIDTH-1:0] C_DEPTH    = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] C_DEPTH_M1 = CNT_WIDTH'(DEPTH - 1);
   localparam logic [PTR_WIDTH-1:0] C_LAST     = PTR_WIDTH'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_WIDTH-1:0]  r_wr_ptr;
   logic [PTR_WIDTH-1:0]  r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  r_req_l;
   logic                  r_ack_r;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  ovf_err;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_rd;
   logic                  w_wr;
   logic [CNT_WIDTH-1:0]  w_count_next;

   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);
   // ack_r gating caps the downstream at one word per two cycles
   assign w_rd    = bus.req_r & ~r_ack_r & ~w_empty;
   assign w_wr    = bus.ack_l & (~w_full | w_rd);

   always_comb begin
      w_count_next = r_count;
      if (w_wr & ~w_rd)
         w_count_next = r_count + CNT_WIDTH'(1);
      else if (w_rd & ~w_wr)
         w_count_next = r_count - CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (w_wr && !rst)
         r_mem[r_wr_ptr] <= bus.din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_req_l  <= 1'b0;
         r_ack_r  <= 1'b0;
         r_dout   <= '0;
         ovf_err  <= 1'b0;
      end else begin
         r_count <= w_count_next;
         r_ack_r <= w_rd;
         if (w_wr)
            r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + PTR_WIDTH'(1);
         if (w_rd) begin
            r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + PTR_WIDTH'(1);
            r_dout   <= r_mem[r_rd_ptr];
         end
         // Toggling at DEPTH-1 leaves at most one acked word in flight for the last slot
         if (w_count_next < C_DEPTH_M1)
            r_req_l <= 1'b1;
         else if (w_count_next == C_DEPTH_M1)
            r_req_l <= ~r_req_l;
         else
            r_req_l <= 1'b0;
         if (bus.ack_l & ~w_wr)
            ovf_err <= 1'b1;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !ovf_err);

   assign bus.req_l = r_req_l;
   assign bus.ack_r = r_ack_r;
   assign bus.dout  = r_dout;
   assign bus.count = r_count;
   assign bus.full  = w_full;
   assign bus.empty = w_empty;

`ifdef HS_FIFO_STATS_EN
   logic [CNT_WIDTH-1:0] r_max_occ;
   logic [31:0]          r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_max_occ   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_count_next > r_max_occ)
            r_max_occ <= w_count_next;
         if (bus.req_r && w_empty && !r_ack_r && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign bus.max_occ   = r_max_occ;
   assign bus.stall_cnt = r_stall_cnt;
`else
   assign bus.max_occ   = '0;
   assign bus.stall_cnt = '0;
`endif
endmodule
